// File: rtl/lcd_text_buffer.sv
// 32-cell character buffer for a 2x16 LCD. A producer streams characters and
// control codes in; the LCD controller reads cells back by index with no latency.
module lcd_text_buffer #(
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  input  logic       clear,
  input  logic [4:0] lcd_index,
  output logic [7:0] lcd_ascii,
  output logic [4:0] cursor,
  output logic       busy
);

  localparam int CELLS = 32;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t     state;
  logic [4:0] sweep;
  logic [7:0] cells [CELLS];

  logic       xfer;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic [4:0] cursor_nxt;
  logic       printable;

  assign char_ready = (state == IDLE) & ~clear & ~reset;
  assign busy       = (state == CLEAR) | reset;
  assign xfer       = char_valid & char_ready;
  assign lcd_ascii  = cells[lcd_index];
  assign printable  = (char_in >= 8'h20) && (char_in <= 8'h7E);

  // One shared write port: the sweep owns it in CLEAR, the producer in IDLE.
  always_comb begin
    wr_en      = 1'b0;
    wr_addr    = cursor;
    wr_data    = char_in;
    cursor_nxt = cursor;
    if (state == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = sweep;
      wr_data = FILL_CHAR;
    end else if (xfer) begin
      if (printable) begin
        wr_en      = 1'b1;
        cursor_nxt = cursor + 5'd1;
      end else begin
        case (char_in)
          8'h0A: cursor_nxt = cursor[4] ? 5'd0 : 5'd16;
          8'h0D: cursor_nxt = cursor[4] ? 5'd16 : 5'd0;
          8'h08: if (cursor != 5'd0) begin
            cursor_nxt = cursor - 5'd1;
            wr_en      = 1'b1;
            wr_addr    = cursor - 5'd1;
            wr_data    = FILL_CHAR;
          end
          default: cursor_nxt = cursor;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state  <= CLEAR;
      sweep  <= 5'd0;
      cursor <= 5'd0;
    end else begin
      case (state)
        CLEAR: begin
          sweep <= sweep + 5'd1;
          if (sweep == 5'd31) state <= IDLE;
        end
        IDLE: begin
          if (clear) begin
            state  <= CLEAR;
            sweep  <= 5'd0;
            cursor <= 5'd0;
          end else begin
            cursor <= cursor_nxt;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Storage has no reset; the sweep that follows reset initialises it.
  always_ff @(posedge CLOCK_50) begin
    if (wr_en && !reset) cells[wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Randomized and directed checks of lcd_text_buffer against a behavioural
// model of the display (cell array, cursor, remaining sweep length).
module tb_lcd_text_buffer;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] char_in = 8'h00;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic       clear = 1'b0;
  logic [4:0] lcd_index = 5'd0;
  logic [7:0] lcd_ascii;
  logic [4:0] cursor;
  logic       busy;

  lcd_text_buffer #(.FILL_CHAR(8'h20)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .char_in   (char_in),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .clear     (clear),
    .lcd_index (lcd_index),
    .lcd_ascii (lcd_ascii),
    .cursor    (cursor),
    .busy      (busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  // Behavioural model of the display.
  logic [7:0] m_cell [32];
  bit         m_known [32];
  int         m_cur = 0;
  int         m_left = 0;   // sweep cycles still to run
  bit         m_acc = 0;    // last edge consumed a character

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit exp_busy();
    return reset || (m_left > 0);
  endfunction

  function automatic bit exp_ready();
    return !exp_busy() && !clear;
  endfunction

  task automatic model_step();
    m_acc = 0;
    if (reset) begin
      m_left = 32;
      m_cur  = 0;
    end else if (m_left > 0) begin
      m_cell[32 - m_left]  = 8'h20;
      m_known[32 - m_left] = 1;
      m_left--;
    end else if (clear) begin
      m_left = 32;
      m_cur  = 0;
    end else if (char_valid) begin
      m_acc = 1;
      if (char_in >= 8'h20 && char_in <= 8'h7E) begin
        m_cell[m_cur]  = char_in;
        m_known[m_cur] = 1;
        m_cur = (m_cur + 1) % 32;
      end else if (char_in == 8'h0A) m_cur = (m_cur < 16) ? 16 : 0;
      else if (char_in == 8'h0D)     m_cur = (m_cur < 16) ? 0 : 16;
      else if (char_in == 8'h08 && m_cur > 0) begin
        m_cur = m_cur - 1;
        m_cell[m_cur]  = 8'h20;
        m_known[m_cur] = 1;
      end
    end
  endtask

  // Single compare process, away from the active edge.
  always @(negedge CLOCK_50) begin
    if (chk_en) begin
      chk("busy", busy, exp_busy());
      chk("char_ready", char_ready, exp_ready());
      chk("cursor", cursor, m_cur);
      if (m_known[lcd_index]) chk("lcd_ascii", lcd_ascii, m_cell[lcd_index]);
    end
  end

  task automatic edge_update();
    @(posedge CLOCK_50);
    model_step();
    #1;
  endtask

  task automatic cyc(input bit r, input bit c, input bit v, input logic [7:0] ch,
                     input logic [4:0] idx);
    reset = r; clear = c; char_valid = v; char_in = ch; lcd_index = idx;
    edge_update();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'h00, 5'($urandom_range(0, 31)));
  endtask

  task automatic wait_sweep();
    int n = 0;
    while (m_left > 0 && n < 40) begin idle(1); n++; end
    if (m_left > 0) chk("sweep_timeout", m_left, 0);
  endtask

  task automatic send(input logic [7:0] ch);
    int n = 0;
    do begin
      cyc(0, 0, 1, ch, 5'($urandom_range(0, 31)));
      n++;
    end while (!m_acc && n < 50);
    if (!m_acc) chk("send_timeout", 0, 1);
    char_valid = 0;
  endtask

  task automatic peek(input string name, input logic [4:0] idx, input logic [7:0] exp);
    reset = 0; clear = 0; char_valid = 0; lcd_index = idx;
    @(negedge CLOCK_50);
    chk(name, lcd_ascii, exp);
    edge_update();
  endtask

  task automatic peek_cursor(input string name, input int exp);
    @(negedge CLOCK_50);
    chk(name, cursor, exp);
    edge_update();
  endtask

  // Counts busy cycles over a 40-cycle window, optionally pulsing clear once.
  task automatic count_busy(input string name, input int clr_at);
    int n = 0;
    for (int i = 0; i < 40; i++) begin
      reset = 0; char_valid = 0; clear = (i == clr_at);
      @(negedge CLOCK_50);
      if (busy) n++;
      edge_update();
    end
    clear = 0;
    chk(name, n, 32);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin m_cell[i] = 8'h00; m_known[i] = 0; end
    // Reset and first sweep.
    cyc(1, 0, 0, 8'h00, 5'd0);
    chk_en = 1;
    cyc(1, 0, 1, 8'h41, 5'd0);
    count_busy("reset_sweep_len", -1);
    for (int i = 0; i < 32; i++) peek("blank_cell", 5'(i), 8'h20);
    peek_cursor("blank_cursor", 0);

    // "HI", newline, "A".
    send(8'h48); send(8'h49); send(8'h0A); send(8'h41);
    peek("hi_c0", 5'd0, 8'h48);
    peek("hi_c1", 5'd1, 8'h49);
    peek("hi_c16", 5'd16, 8'h41);
    peek_cursor("hi_cursor", 17);

    // 33 stars wrap the cursor.
    cyc(0, 1, 0, 8'h00, 5'd0); wait_sweep();
    for (int i = 0; i < 33; i++) send(8'h2A);
    for (int i = 0; i < 32; i++) peek("star_cell", 5'(i), 8'h2A);
    peek_cursor("star_cursor", 1);

    // Backspace past home is a no-op that still completes.
    cyc(0, 1, 0, 8'h00, 5'd0); wait_sweep();
    send(8'h41); send(8'h08);
    reset = 0; clear = 0; char_valid = 1; char_in = 8'h08;
    @(negedge CLOCK_50);
    chk("bs_ready", char_ready, 1);
    edge_update();
    char_valid = 0;
    peek("bs_c0", 5'd0, 8'h20);
    peek_cursor("bs_cursor", 0);

    // Clear beats a simultaneous character.
    send(8'h42);
    reset = 0; clear = 1; char_valid = 1; char_in = 8'h5A;
    @(negedge CLOCK_50);
    chk("clr_win_ready", char_ready, 0);
    edge_update();
    clear = 0; char_valid = 0;
    @(negedge CLOCK_50);
    chk("clr_win_busy", busy, 1);
    edge_update();
    wait_sweep();
    peek("clr_win_c0", 5'd0, 8'h20);
    send(8'h5A);
    peek("clr_win_resend", 5'd0, 8'h5A);

    // Reset mid-sweep restarts a full sweep; clear mid-sweep does not extend it.
    cyc(0, 1, 0, 8'h00, 5'd0);
    idle(10);
    cyc(1, 0, 0, 8'h00, 5'd0);
    cyc(1, 0, 0, 8'h00, 5'd0);
    count_busy("rst_mid_sweep_len", 5);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] ch;
      case ($urandom_range(0, 5))
        0, 1:    ch = 8'($urandom_range(8'h20, 8'h7E));
        2:       ch = 8'h0A;
        3:       ch = 8'h0D;
        4:       ch = 8'h08;
        default: ch = 8'($urandom);
      endcase
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 59) == 0),
          $urandom_range(0, 1) == 1, ch, 5'($urandom_range(0, 31)));
    end
    idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
